rx: RTL



---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive stages: state encoding,
// parity codes and the layout of the common configuration word.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int CFG_PAR_LO = 4;
  localparam int CFG_RSVD   = 3;
  localparam int CFG_STOP   = 2;
  localparam int CFG_DBITS  = 0;

  typedef struct packed {
    logic [1:0] par;
    logic       rsvd;
    logic       stop;
    logic [1:0] dbits;
  } cfg_t;

  // Index of the last data bit: character length is dbits + 5.
  function automatic logic [2:0] data_last(input logic [1:0] dbits);
    return 3'd4 + {1'b0, dbits};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, 2 clk latency;
// reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional parity, 1-2 stop bits.
// Character lands in a one-entry buffer the clk after the last stop sample; newest wins on overrun.
module rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       uart_rx,
  input  logic [5:0] configs,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       state_out
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

  logic rxs;
  logic rxs_prev_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (uart_rx),
    .sync_o  (rxs)
  );

  uart_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  cfg_t          cfg_q, cfg_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          complete;
  logic          par_en;
  logic          cfg_unused;

  assign par_en     = (cfg_q.par == PAR_ODD) || (cfg_q.par == PAR_EVEN);
  assign cfg_unused = cfg_q.rsvd;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    cfg_d        = cfg_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          state_d = ST_START;
          tick_d  = '0;
          cfg_d   = cfg_t'(configs);
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (rxs) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
              shift_d = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
          if (tick_q == TICK_LAST) begin
            shift_d[bit_q] = rxs;
            if (bit_q == data_last(cfg_q.dbits)) begin
              bit_d   = '0;
              state_d = par_en ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
          if (tick_q == TICK_LAST) begin
            perr_d  = ((^shift_q) ^ rxs) != (cfg_q.par == PAR_ODD);
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
          if (tick_q == TICK_LAST) begin
            ferr_d = ferr_q | ~rxs;
            if (bit_q == {2'b00, cfg_q.stop}) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A read coinciding with a completion consumes the old character, so no overrun.
    if (complete) begin
      rx_data_d    = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_q | ~rxs;
      rx_valid_d   = 1'b1;
      overrun_d    = rx_rd ? 1'b0 : (rx_valid_q | overrun_q);
    end else if (rx_rd && rx_valid_q) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxs_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      cfg_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rxs_prev_q   <= rxs;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      cfg_q        <= cfg_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign state_out  = (state_q != ST_IDLE);

endmodule
